// File: rtl/csr_pkg.sv
// Shared CSR address map, bit positions, trap cause codes and FSM states
// for the machine-mode CSR/interrupt unit.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIE_MTIE     = 7;
  localparam int unsigned MIE_MEIE     = 11;
  localparam int unsigned MIP_MTIP     = 7;
  localparam int unsigned MIP_MEIP     = 11;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  typedef enum logic {CSR_RUN, CSR_WAIT} csr_state_e;

  // funct3[1:0]: 01 RW, 10 RS, 11 RC
  function automatic logic [31:0] csr_apply(input logic [1:0] op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    case (op)
      2'b01:   return wdata;
      2'b10:   return old_val | wdata;
      2'b11:   return old_val & ~wdata;
      default: return old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// Free-running counter with increment enable, exposed as 32-bit lo/hi words.
module csr_counter64 #(
  parameter int unsigned W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end

  assign lo = cnt[31:0];
  assign hi = 32'(cnt >> 32);

endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file and interrupt/trap sequencer for the EX stage:
// CSR read/modify/write, trap entry, MRET and WFI sleep.
module csr_irq_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0001_0000,
  parameter int unsigned CNT_W       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        csr_we,
  input  logic [2:0]  csr_funct3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        mret_i,
  input  logic        wfi_i,
  input  logic        instr_retire,
  input  logic        ext_irq,
  input  logic        timer_irq,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        wfi_stall
);

  csr_state_e  state_q, state_d;
  logic        mst_mie, mst_mpie;
  logic        mie_meie, mie_mtie;
  logic [29:0] mtvec_q, mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] wfi_pc_q;

  logic [31:0] cyc_lo, cyc_hi, ret_lo, ret_hi;
  logic [1:0]  pend;
  logic        trap, do_csr, do_mret, do_wfi;
  logic [31:0] trap_pc;
  logic [31:0] csr_new;
  logic [3:0]  unused_bits;

  csr_counter64 #(.W(CNT_W)) u_mcycle (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .lo  (cyc_lo),
    .hi  (cyc_hi)
  );

  csr_counter64 #(.W(CNT_W)) u_minstret (
    .clk (clk),
    .rst (rst),
    .en  (instr_retire),
    .lo  (ret_lo),
    .hi  (ret_hi)
  );

  assign pend = {ext_irq & mie_meie, timer_irq & mie_mtie};

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[12:11]        = 2'b11;
        csr_rdata[MSTATUS_MPIE] = mst_mpie;
        csr_rdata[MSTATUS_MIE]  = mst_mie;
      end
      CSR_MIE: begin
        csr_rdata[MIE_MEIE] = mie_meie;
        csr_rdata[MIE_MTIE] = mie_mtie;
      end
      CSR_MIP: begin
        csr_rdata[MIP_MEIP] = ext_irq;
        csr_rdata[MIP_MTIP] = timer_irq;
      end
      CSR_MTVEC:                 csr_rdata = {mtvec_q, 2'b00};
      CSR_MEPC:                  csr_rdata = {mepc_q, 2'b00};
      CSR_MCAUSE:                csr_rdata = mcause_q;
      CSR_MCYCLE,   CSR_CYCLE:   csr_rdata = cyc_lo;
      CSR_MCYCLEH,  CSR_CYCLEH:  csr_rdata = cyc_hi;
      CSR_MINSTRET, CSR_INSTRET: csr_rdata = ret_lo;
      CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = ret_hi;
      default:                   csr_rdata = '0;
    endcase
  end

  assign csr_new     = csr_apply(csr_funct3[1:0], csr_rdata, csr_wdata);
  assign unused_bits = {csr_funct3[2], csr_new[1:0], 1'b0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= CSR_RUN;
    else      state_q <= state_d;
  end

  // A trap squashes the EX instruction; in WAIT the EX inputs are ignored and
  // a wake-up trap saves the address following the WFI.
  always_comb begin
    state_d   = state_q;
    trap      = 1'b0;
    do_csr    = 1'b0;
    do_mret   = 1'b0;
    do_wfi    = 1'b0;
    trap_pc   = ex_pc;
    wfi_stall = 1'b0;
    case (state_q)
      CSR_RUN: begin
        if (ex_valid) begin
          if (mst_mie && (pend != 2'b00)) begin
            trap = 1'b1;
          end else begin
            do_csr  = csr_we;
            do_mret = mret_i;
            if (wfi_i && (pend == 2'b00)) begin
              do_wfi  = 1'b1;
              state_d = CSR_WAIT;
            end
          end
        end
      end
      CSR_WAIT: begin
        if (pend != 2'b00) begin
          state_d = CSR_RUN;
          trap    = mst_mie;
          trap_pc = wfi_pc_q + 32'd4;
        end else begin
          wfi_stall = 1'b1;
        end
      end
      default: state_d = CSR_RUN;
    endcase
  end

  assign redirect    = trap | do_mret;
  assign redirect_pc = trap ? {mtvec_q, 2'b00} : {mepc_q, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
      mie_meie <= 1'b0;
      mie_mtie <= 1'b0;
      mtvec_q  <= MTVEC_RESET[31:2];
      mepc_q   <= '0;
      mcause_q <= '0;
      wfi_pc_q <= '0;
    end else begin
      if (trap) begin
        mepc_q   <= trap_pc[31:2];
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
        mcause_q <= pend[1] ? CAUSE_MEI : CAUSE_MTI;
      end else begin
        if (do_csr) begin
          case (csr_addr)
            CSR_MSTATUS: begin
              mst_mie  <= csr_new[MSTATUS_MIE];
              mst_mpie <= csr_new[MSTATUS_MPIE];
            end
            CSR_MIE: begin
              mie_meie <= csr_new[MIE_MEIE];
              mie_mtie <= csr_new[MIE_MTIE];
            end
            CSR_MTVEC: mtvec_q <= csr_new[31:2];
            CSR_MEPC:  mepc_q  <= csr_new[31:2];
            default: ;
          endcase
        end
        if (do_mret) begin
          mst_mie  <= mst_mpie;
          mst_mpie <= 1'b1;
        end
      end
      if (do_wfi) wfi_pc_q <= ex_pc;
    end
  end

endmodule

// File: doc/csr_irq_unit.md
Name: csr_irq_unit

Overview:
- Machine-mode CSR file and interrupt/trap sequencer in the EX stage of the 5-stage RV32 pipeline.
- Consumes the per-instruction CSR-write, MRET and WFI flags produced by ID decode (carried through ID/EX) plus the external and timer interrupt lines.
- Provides CSR read data for write-back, PC redirect (trap/MRET) with pipeline flush, and a WFI stall.

Parameters:
MTVEC_RESET, 32'h0001_0000, reset value of mtvec (direct mode, bits[1:0]=0)
CNT_W, 64, width of mcycle/minstret counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
ex_valid  in  1  EX holds a real (non-bubble) instruction
ex_pc  in  32  PC of the EX instruction
csr_we  in  1  CSR write request (decoded CSR op, funct3!=000)
csr_funct3  in  3  CSR op: x01 RW, x10 RS, x11 RC
csr_addr  in  12  CSR address (inst[31:20])
csr_wdata  in  32  rs1 value or zero-extended zimm (muxed upstream)
mret_i  in  1  EX instruction is MRET
wfi_i  in  1  EX instruction is WFI
instr_retire  in  1  one instruction retires this cycle
ext_irq  in  1  external interrupt level (MEIP)
timer_irq  in  1  timer interrupt level (MTIP)
csr_rdata  out  32  old CSR value for rd write-back (combinational)
redirect  out  1  flush IF/ID/EX and load redirect_pc (combinational)
redirect_pc  out  32  target: mtvec on trap, mepc on MRET
wfi_stall  out  1  freeze PC, IF/ID, ID/EX while sleeping

Behaviour:
- Registers and reset values:
  - mstatus 0x0000_1800: MIE[3], MPIE[7] writable; MPP[12:11] fixed 11; other bits read 0.
  - mie 0: MEIE[11], MTIE[7] writable.
  - mip: read-only MEIP[11]=ext_irq, MTIP[7]=timer_irq.
  - mtvec MTVEC_RESET: [31:2] writable, [1:0]=0.
  - mepc 0: [31:2] writable, [1:0]=0.
  - mcause 0: read-only, set by trap.
  - mcycle/minstret 0.
  - FSM in RUN.
- Address map:
  - 300 mstatus, 304 mie, 305 mtvec, 341 mepc, 342 mcause, 344 mip.
  - B00/B80 mcycle lo/hi, B02/B82 minstret lo/hi.
  - C00/C80/C02/C82 are user aliases of the same counters.
  - Unmapped addresses read 0 and ignore writes. Counters are read-only; writes are ignored.
- CSR write (ex_valid & csr_we & no trap this cycle), applied at the clock edge:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - csr_rdata always returns the pre-write value.
- Counters:
  - mcycle increments every cycle, including during a stall.
  - minstret increments when instr_retire is high.
  - Both wrap at 2^CNT_W.
- pend = {ext_irq&MEIE, timer_irq&MTIE}.
- Trap, RUN state: taken when ex_valid & mstatus.MIE & |pend.
  - Same cycle: redirect=1, redirect_pc=mtvec; the EX instruction is squashed (its CSR write, MRET and WFI effects are suppressed).
  - At the edge: mepc<=ex_pc, MPIE<=MIE, MIE<=0.
  - mcause <= 0x8000_000B if MEI pending, else 0x8000_0007. External has priority over timer.
- MRET (ex_valid & mret_i, no trap):
  - redirect=1, redirect_pc=mepc.
  - At the edge: MIE<=MPIE, MPIE<=1.
- WFI (ex_valid & wfi_i, no trap):
  - If pend==0: latch wfi_pc<=ex_pc and go to WAIT.
  - Otherwise WFI acts as a NOP.
- WAIT state:
  - wfi_stall=1. csr_we, mret_i, wfi_i and ex_valid are ignored. Counters keep running.
  - On pend!=0 with MIE=1: go to RUN, take the trap with mepc<=wfi_pc+4, redirect to mtvec; wfi_stall=0 in that cycle.
  - On pend!=0 with MIE=0: go to RUN, wfi_stall=0, no redirect; execution resumes after the WFI.
- Outputs are 0 in RUN when no event occurs.
- Reset asserted mid-WAIT or mid-trap returns everything to reset values immediately; wfi_stall drops asynchronously.

Decomposition:
- Shared package csr_pkg:
  - CSR address localparams (CSR_MSTATUS ... CSR_INSTRETH).
  - Bit-index constants (MSTATUS_MIE=3, MSTATUS_MPIE=7, MIP_MTIP=7, MIP_MEIP=11).
  - Cause codes (CAUSE_MEI=32'h8000_000B, CAUSE_MTI=32'h8000_0007).
  - FSM typedef enum {CSR_RUN, CSR_WAIT}.
- One sub-module: csr_counter64, holding a 64-bit counter with increment enable and lo/hi read.

Test Plan:
- Reset release, then read 300, 305, B00 → 0x1800, MTVEC_RESET; mcycle equals elapsed cycles.
- CSRRW 305 with wdata 0x0002_0003 → rdata returns the old value; mtvec reads 0x0002_0000. CSRRS 300 with 0x8 → MIE=1. CSRRC 300 with 0x8 → MIE=0.
- MIE=1, MEIE=1, ext_irq=1 while ex_pc=0x100 → redirect to mtvec in the same cycle; mepc=0x100, mcause=0x8000_000B, MIE=0, MPIE=1. Then MRET → redirect_pc=0x100, MIE=1.
- ext_irq and timer_irq rise together with both enabled → mcause=0x8000_000B. Trap coinciding with a CSRRW to mie → write suppressed.
- WFI at 0x200 with pend=0 → wfi_stall stays high 10 cycles. timer_irq with MTIE=1, MIE=1 → trap with mepc=0x204; with MIE=0 → resume with no redirect.
- Assert rst while in WAIT → wfi_stall=0 asynchronously; all CSRs return to reset values.
